wb_sram_arbiter: RTL and testbench

WB_SRAM_ARBITER -- requirements
Module: wb_sram_arbiter

---
 rtl/wb_sram_pkg.sv | 16 +
 rtl/wb_sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_sram_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_pkg.sv
// rtl/wb_sram_pkg.sv - shared types and constants for the SRAM Wishbone arbiter
//
// Contents:
//   arb_state_e          arbiter FSM state encoding (IDLE, BUSY, ERR)
//   TIMEOUT_CYC_DEFAULT  default number of unacknowledged cycles before an error termination
package wb_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

endpackage : wb_sram_pkg

// File: rtl/wb_sram_arbiter.sv
// rtl/wb_sram_arbiter.sv - two-master round-robin Wishbone arbiter in front of one SRAM slave
//
// Ports:
//   wb_clk_i, wb_rst_i         sole clock; asynchronous active-high reset
//   m0_cyc_i .. m0_adr_i       master 0 (Caravel) request: cyc, stb, we, sel, write data, address
//   m0_ack_o, m0_err_o, m0_dat_o  master 0 termination and read data
//   m1_*                       same set for master 1 (on-chip user logic)
//   s_cyc_o .. s_adr_o         request forwarded to the SRAM wrapper
//   s_ack_i, s_dat_i           SRAM wrapper acknowledge and read data
//   grant_o                    one-hot owner (bit0 = m0, bit1 = m1), 2'b00 when idle
module wb_sram_arbiter
  import wb_sram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;  // 0 = m0, 1 = m1
  logic       prio_q,  prio_d;   // master that wins a tie; flips to the other one on release
  logic [7:0] cnt_q,   cnt_d;

  logic req0, req1;
  logic own_cyc, own_stb;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_d = ST_BUSY;
          owner_d = (req0 & req1) ? prio_q : req1;
          cnt_d   = 8'd0;
        end
      end
      ST_BUSY: begin
        // Releasing the bus takes priority; a master holding cyc keeps the grant
        // across beats so block transfers are never split.
        if (!own_cyc) begin
          state_d = ST_IDLE;
          prio_d  = ~owner_q;
        end else if (s_ack_i) begin
          cnt_d = 8'd0;
        end else if (own_stb) begin
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        prio_d  = ~owner_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slave-side request and master-side terminations are purely combinational
  // so the arbiter adds no latency to an SRAM access.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_dat_o  = 32'h0;
    s_adr_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'h0;
    grant_o  = 2'b00;

    if (state_q == ST_BUSY) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      s_we_o  = owner_q ? m1_we_i  : m0_we_i;
      s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
      s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
      s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
      if (owner_q) begin
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
    end

    if (state_q == ST_ERR) begin
      if (owner_q) begin
        m1_err_o = 1'b1;
      end else begin
        m0_err_o = 1'b1;
      end
    end

    if (state_q != ST_IDLE) begin
      grant_o = owner_q ? 2'b10 : 2'b01;
    end
  end

endmodule : wb_sram_arbiter

// File: tb/tb_wb_sram_arbiter.sv
// tb/tb_wb_sram_arbiter.sv - self-checking bench for wb_sram_arbiter
module tb_wb_sram_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mc_cyc, mc_stb, mc_we;
  logic [3:0]  mc_sel [2];
  logic [31:0] mc_dat [2];
  logic [31:0] mc_adr [2];
  logic [1:0]  m_ack, m_err;
  logic [31:0] m0_dat, m1_dat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_wdat, s_adr;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;

  wb_sram_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .wb_clk_i(clk),       .wb_rst_i(rst),
    .m0_cyc_i(mc_cyc[0]), .m0_stb_i(mc_stb[0]), .m0_we_i(mc_we[0]),
    .m0_sel_i(mc_sel[0]), .m0_dat_i(mc_dat[0]), .m0_adr_i(mc_adr[0]),
    .m0_ack_o(m_ack[0]),  .m0_err_o(m_err[0]),  .m0_dat_o(m0_dat),
    .m1_cyc_i(mc_cyc[1]), .m1_stb_i(mc_stb[1]), .m1_we_i(mc_we[1]),
    .m1_sel_i(mc_sel[1]), .m1_dat_i(mc_dat[1]), .m1_adr_i(mc_adr[1]),
    .m1_ack_o(m_ack[1]),  .m1_err_o(m_err[1]),  .m1_dat_o(m1_dat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_dat_o(s_wdat), .s_adr_o(s_adr), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_cnt [2];
  int          gnt_cycles = 0;
  bit          noack = 1'b0;
  bit          poke_ack = 1'b0;
  bit          trace_en = 1'b0;
  logic [1:0]  tr[$];
  logic [1:0]  last_tr;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] sread(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic trace_start();
    tr.delete();
    last_tr  = 2'b00;
    trace_en = 1'b1;
  endtask

  // seq holds n two-bit grant values, first expected value in the most significant slot
  task automatic check_trace(input string nm, input int n, input logic [15:0] seq);
    trace_en = 1'b0;
    check($sformatf("%s_len", nm), 64'(tr.size()), 64'(n));
    for (int i = 0; i < n && i < tr.size(); i++)
      check($sformatf("%s_%0d", nm, i), 64'(tr[i]), 64'(seq[2*(n-1-i) +: 2]));
  endtask

  // mode: 0 read, 1 write, 2 random; fix selects the given address/data with all bytes
  task automatic master_txn(input int m, input int nb, input int mode, input bit exp_err,
                            input bit fix, input logic [31:0] fadr, input logic [31:0] fdat);
    logic [31:0] a, d;
    logic [3:0]  sl;
    bit          w, got;
    exp_t        e;
    for (int b = 0; b < nb; b++) begin
      a  = fix ? fadr : ((m == 0 ? 32'h0000_8000 : 32'h0001_0000) + 32'(4 * $urandom_range(0, 7)));
      d  = fix ? fdat : $urandom;
      sl = fix ? 4'hF : 4'($urandom_range(1, 15));
      w  = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      @(posedge clk); #1;
      mc_cyc[m] = 1'b1; mc_stb[m] = 1'b1; mc_we[m] = w;
      mc_sel[m] = sl;   mc_dat[m] = d;    mc_adr[m] = a;
      e.is_err = exp_err;
      e.chk    = !w && !exp_err;
      e.dat    = mread(a);
      if (w && !exp_err) model_mem[a] = merge(mread(a), d, sl);
      if (m == 0) q0.push_back(e); else q1.push_back(e);
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (m_ack[m] | m_err[m]) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("term_seen_m%0d", m), 64'(got), 64'd1);
      if (!got || m_err[m]) break;
    end
    @(posedge clk); #1;
    mc_cyc[m] = 1'b0; mc_stb[m] = 1'b0; mc_we[m] = 1'b0;
  endtask

  initial begin
    int a0, a1, g, e, gc0, own;
    bit got;
    mc_cyc = '0; mc_stb = '0; mc_we = '0;
    for (int i = 0; i < 2; i++) begin
      mc_sel[i] = 4'h0; mc_dat[i] = 32'h0; mc_adr[i] = 32'h0; ack_cnt[i] = 0;
    end
    s_ack  = 1'b0;
    s_rdat = 32'h0;

    fork
      // SRAM slave: acks 1..3 cycles after seeing a request, junk data when not acking
      begin : slave
        int wc, lat;
        logic nxt_ack;
        logic [31:0] nxt_dat;
        wc = 0; lat = 0;
        forever begin
          @(negedge clk);
          nxt_ack = 1'b0;
          nxt_dat = $urandom;
          if (rst) begin
            wc = 0;
          end else if (s_ack) begin
            if (s_cyc && s_stb && s_we) slave_mem[s_adr] = merge(sread(s_adr), s_wdat, s_sel);
            wc = 0;
          end else if (poke_ack) begin
            nxt_ack = 1'b1;
          end else if (s_cyc && s_stb && !noack) begin
            if (wc == 0) lat = $urandom_range(0, 2);
            if (wc >= lat) begin
              nxt_ack = 1'b1;
              if (!s_we) nxt_dat = sread(s_adr);
            end else begin
              wc++;
            end
          end else begin
            wc = 0;
          end
          @(posedge clk); #1;
          s_ack  = nxt_ack;
          s_rdat = nxt_dat;
        end
      end
      // Monitor: scoreboard pops on every termination, plus bus-routing invariants
      begin : monitor
        exp_t ex;
        forever begin
          @(negedge clk);
          if (trace_en && grant !== last_tr) begin
            tr.push_back(grant);
            last_tr = grant;
          end
          if (grant != 2'b00) gnt_cycles++;
          for (int m = 0; m < 2; m++) begin
            if (m_ack[m] | m_err[m]) begin
              if (m_ack[m]) ack_cnt[m]++;
              if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("unexpected_term_m%0d", m), 64'(m_ack[m] | m_err[m]), 64'd0);
              end else begin
                ex = (m == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("term_is_err_m%0d", m), 64'(m_err[m]), 64'(ex.is_err));
                if (m_ack[m] && ex.chk)
                  check($sformatf("rd_data_m%0d", m), 64'(m == 0 ? m0_dat : m1_dat), 64'(ex.dat));
              end
            end
          end
          check("grant_legal", 64'(grant == 2'b11), 64'd0);
          if (grant == 2'b00) begin
            check("idle_quiet", 64'({s_cyc, s_stb, s_we, s_sel, m_ack, m_err}), 64'd0);
            check("idle_dat", {m0_dat, m1_dat}, 64'd0);
            check("idle_bus", {s_adr, s_wdat}, 64'd0);
          end else begin
            own = grant[1] ? 1 : 0;
            check("nonowner_quiet",
                  64'({m_ack[1-own], m_err[1-own], (own == 1 ? m0_dat : m1_dat)}), 64'd0);
            if (m_err[own]) begin
              check("err_bus", 64'({s_cyc, s_stb, m_ack[own]}), 64'd0);
            end else begin
              check("bus_mirror", 64'({s_cyc, s_stb, s_we, s_sel, s_adr}),
                    64'({mc_cyc[own], mc_stb[own], mc_we[own], mc_sel[own], mc_adr[own]}));
              check("bus_wdat", 64'(s_wdat), 64'(mc_dat[own]));
              check("ack_pass", 64'(m_ack[own]), 64'(s_ack));
              check("rdat_pass", 64'(own == 1 ? m1_dat : m0_dat), 64'(s_rdat));
            end
          end
        end
      end
      begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, want summary before 1 ms");
        $fatal(1, "bench time limit expired");
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_quiet", 64'({s_cyc, s_stb, m_ack, m_err}), 64'd0);
    check("rst_dat", {m0_dat, m1_dat}, 64'd0);
    rst = 1'b0;

    // simultaneous requests straight out of reset: m0 first, one idle cycle, then m1
    trace_start();
    fork
      master_txn(0, 1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      master_txn(1, 1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    join
    idle(4);
    check_trace("rr_reset", 4, 16'b01_00_10_00);

    // m0 single write, m1 untouched, then read it back
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    trace_start();
    master_txn(0, 1, 1, 1'b0, 1'b1, 32'h0000_8004, 32'hDEAD_BEEF);
    idle(3);
    check_trace("m0_write", 2, 16'b01_00);
    check("m0_write_acks", 64'(ack_cnt[0] - a0), 64'd1);
    check("m0_write_m1_acks", 64'(ack_cnt[1] - a1), 64'd0);
    master_txn(0, 1, 0, 1'b0, 1'b1, 32'h0000_8004, 32'h0);
    idle(2);

    // m1 four-beat read burst holds the bus while m0 waits
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    trace_start();
    fork
      master_txn(1, 4, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      begin
        idle(2);
        master_txn(0, 1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    join
    idle(3);
    check_trace("burst_hold", 4, 16'b10_00_01_00);
    check("burst_m1_acks", 64'(ack_cnt[1] - a1), 64'd4);
    check("burst_m0_acks", 64'(ack_cnt[0] - a0), 64'd1);

    // silent slave: error on the 17th cycle counting the first granted cycle as 1
    noack = 1'b1;
    fork
      master_txn(0, 1, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      begin
        g = -1; e = -1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (g < 0 && grant != 2'b00) g = cyc_cnt;
          if (m_err[0]) begin
            e = cyc_cnt;
            check("to_scyc_low", 64'(s_cyc), 64'd0);
            break;
          end
        end
        check("to_err_cycle", 64'(e - g), 64'd16);
        @(negedge clk);
        check("to_back_idle", 64'(grant), 64'd0);
      end
    join
    noack = 1'b0;
    idle(2);

    // request dropped right after it was sampled: one-cycle grant, then release
    trace_start();
    gc0 = gnt_cycles;
    @(posedge clk); #1;
    mc_cyc[0] = 1'b1; mc_stb[0] = 1'b1; mc_we[0] = 1'b0; mc_adr[0] = 32'h0000_8000;
    @(posedge clk); #1;
    mc_cyc[0] = 1'b0; mc_stb[0] = 1'b0;
    idle(3);
    check_trace("drop_grant", 2, 16'b01_00);
    check("drop_gnt_cycles", 64'(gnt_cycles - gc0), 64'd1);

    // stray slave ack while idle is ignored
    @(posedge clk); #1;
    poke_ack = 1'b1;
    @(negedge clk); #1;
    poke_ack = 1'b0;
    @(negedge clk);
    check("stray_ack", 64'({m_ack, m_err}), 64'd0);
    idle(2);

    // reset mid-transfer (m0 was last released, so only reset can restore m0 priority)
    noack = 1'b1;
    @(posedge clk); #1;
    mc_cyc[0] = 1'b1; mc_stb[0] = 1'b1; mc_we[0] = 1'b0; mc_adr[0] = 32'h0000_8010;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant == 2'b01) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_pre_grant", 64'(got), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bus", 64'({s_cyc, s_stb}), 64'd0);
    check("rst_mid_grant", 64'(grant), 64'd0);
    check("rst_mid_term", 64'({m_ack, m_err}), 64'd0);
    @(posedge clk); #1;
    mc_cyc[1] = 1'b1; mc_stb[1] = 1'b1; mc_we[1] = 1'b0; mc_adr[1] = 32'h0001_0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rr_m0", 64'(grant), 64'd1);
    @(posedge clk); #1;
    mc_cyc = '0; mc_stb = '0;
    noack = 1'b0;
    idle(4);

    // random concurrent traffic from both masters
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          idle($urandom_range(0, 3));
          master_txn(0, $urandom_range(1, 4), 2, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          idle($urandom_range(0, 3));
          master_txn(1, $urandom_range(1, 4), 2, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    join
    idle(5);
    check("sb_empty_m0", 64'(q0.size()), 64'd0);
    check("sb_empty_m1", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_sram_arbiter
